// File: rtl/axi4_burst_mem_slave.sv
// AXI4 memory slave with independent single-outstanding write and read paths.
// INCR and FIXED bursts are served from an internal word array; other bursts answer SLVERR.
//
// state  | meaning
// W_IDLE | waiting for AW (awready high once out of reset)
// W_DATA | accepting write beats, count runs 0..awlen
// W_RESP | holding B response until bready
// R_IDLE | waiting for AR (arready high once out of reset)
// R_DATA | presenting read beat; next beat loads on the handshake edge
module axi4_burst_mem_slave #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int MEM_DEPTH  = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic [ID_WIDTH-1:0]     s_axi_awid,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [7:0]              s_axi_awlen,
   input  logic [2:0]              s_axi_awsize,
   input  logic [1:0]              s_axi_awburst,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wlast,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [ID_WIDTH-1:0]     s_axi_bid,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [ID_WIDTH-1:0]     s_axi_arid,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [7:0]              s_axi_arlen,
   input  logic [2:0]              s_axi_arsize,
   input  logic [1:0]              s_axi_arburst,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [ID_WIDTH-1:0]     s_axi_rid,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rlast,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int OFFS   = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(MEM_DEPTH);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   function automatic logic [ADDR_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
      return (a - BASE_ADDR) >> OFFS;
   endfunction

   function automatic logic addr_oob(input logic [ADDR_WIDTH-1:0] a);
      return (a < BASE_ADDR) || (word_idx(a) >= ADDR_WIDTH'(MEM_DEPTH));
   endfunction

   function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
      return burst[1] || (size > 3'(OFFS));
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [1:0] burst,
                                                       input logic [2:0] size);
      return (burst == 2'b00) ? a : a + (ADDR_WIDTH'(1) << size);
   endfunction

   // Holds both ready outputs low until the first edge after reset release.
   logic init_q;

   w_state_e              w_state_q, w_state_d;
   logic [ID_WIDTH-1:0]   awid_q, awid_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [7:0]            awlen_q, awlen_d, wcnt_q, wcnt_d;
   logic [2:0]            awsize_q, awsize_d;
   logic [1:0]            awburst_q, awburst_d;
   logic                  werr_q, werr_d;
   logic                  mem_we;
   logic [IDX_W-1:0]      mem_widx;

   r_state_e              r_state_q, r_state_d;
   logic [ID_WIDTH-1:0]   arid_q, arid_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, raddr_nxt;
   logic [7:0]            arlen_q, arlen_d, rcnt_q, rcnt_d;
   logic [2:0]            arsize_q, arsize_d;
   logic [1:0]            arburst_q, arburst_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic                  rbad;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         init_q    <= 1'b0;
         w_state_q <= W_IDLE;
         awid_q    <= '0;
         waddr_q   <= '0;
         awlen_q   <= '0;
         awsize_q  <= '0;
         awburst_q <= '0;
         wcnt_q    <= '0;
         werr_q    <= 1'b0;
         r_state_q <= R_IDLE;
         arid_q    <= '0;
         raddr_q   <= '0;
         arlen_q   <= '0;
         arsize_q  <= '0;
         arburst_q <= '0;
         rcnt_q    <= '0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         init_q    <= 1'b1;
         w_state_q <= w_state_d;
         awid_q    <= awid_d;
         waddr_q   <= waddr_d;
         awlen_q   <= awlen_d;
         awsize_q  <= awsize_d;
         awburst_q <= awburst_d;
         wcnt_q    <= wcnt_d;
         werr_q    <= werr_d;
         r_state_q <= r_state_d;
         arid_q    <= arid_d;
         raddr_q   <= raddr_d;
         arlen_q   <= arlen_d;
         arsize_q  <= arsize_d;
         arburst_q <= arburst_d;
         rcnt_q    <= rcnt_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   always_comb begin
      w_state_d     = w_state_q;
      awid_d        = awid_q;
      waddr_d       = waddr_q;
      awlen_d       = awlen_q;
      awsize_d      = awsize_q;
      awburst_d     = awburst_q;
      wcnt_d        = wcnt_q;
      werr_d        = werr_q;
      mem_we        = 1'b0;
      mem_widx      = IDX_W'(word_idx(waddr_q));
      s_axi_awready = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_bvalid  = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            s_axi_awready = init_q;
            if (init_q && s_axi_awvalid) begin
               awid_d    = s_axi_awid;
               waddr_d   = s_axi_awaddr;
               awlen_d   = s_axi_awlen;
               awsize_d  = s_axi_awsize;
               awburst_d = s_axi_awburst;
               wcnt_d    = '0;
               werr_d    = 1'b0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            s_axi_wready = 1'b1;
            if (s_axi_wvalid) begin
               mem_we  = !burst_bad(awburst_q, awsize_q) && !addr_oob(waddr_q);
               werr_d  = werr_q || burst_bad(awburst_q, awsize_q) || addr_oob(waddr_q) ||
                         (s_axi_wlast != (wcnt_q == awlen_q));
               waddr_d = next_addr(waddr_q, awburst_q, awsize_q);
               wcnt_d  = wcnt_q + 8'd1;
               if (wcnt_q == awlen_q) w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            s_axi_bvalid = 1'b1;
            if (s_axi_bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   assign s_axi_bid   = awid_q;
   assign s_axi_bresp = werr_q ? RESP_SLVERR : RESP_OKAY;

   always_ff @(posedge aclk) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (s_axi_wstrb[b]) mem_q[mem_widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
         end
      end
   end

   always_comb begin
      r_state_d     = r_state_q;
      arid_d        = arid_q;
      raddr_d       = raddr_q;
      arlen_d       = arlen_q;
      arsize_d      = arsize_q;
      arburst_d     = arburst_q;
      rcnt_d        = rcnt_q;
      rdata_d       = rdata_q;
      rresp_d       = rresp_q;
      raddr_nxt     = next_addr(raddr_q, arburst_q, arsize_q);
      rbad          = 1'b0;
      s_axi_arready = 1'b0;
      s_axi_rvalid  = 1'b0;
      s_axi_rlast   = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            s_axi_arready = init_q;
            if (init_q && s_axi_arvalid) begin
               rbad      = burst_bad(s_axi_arburst, s_axi_arsize) || addr_oob(s_axi_araddr);
               arid_d    = s_axi_arid;
               raddr_d   = s_axi_araddr;
               arlen_d   = s_axi_arlen;
               arsize_d  = s_axi_arsize;
               arburst_d = s_axi_arburst;
               rcnt_d    = '0;
               rdata_d   = rbad ? '0 : mem_q[IDX_W'(word_idx(s_axi_araddr))];
               rresp_d   = rbad ? RESP_SLVERR : RESP_OKAY;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            s_axi_rvalid = 1'b1;
            s_axi_rlast  = (rcnt_q == arlen_q);
            if (s_axi_rready) begin
               if (rcnt_q == arlen_q) begin
                  r_state_d = R_IDLE;
               end else begin
                  rbad    = burst_bad(arburst_q, arsize_q) || addr_oob(raddr_nxt);
                  raddr_d = raddr_nxt;
                  rcnt_d  = rcnt_q + 8'd1;
                  rdata_d = rbad ? '0 : mem_q[IDX_W'(word_idx(raddr_nxt))];
                  rresp_d = rbad ? RESP_SLVERR : RESP_OKAY;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   assign s_axi_rid   = arid_q;
   assign s_axi_rdata = rdata_q;
   assign s_axi_rresp = rresp_q;

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Directed bench for axi4_burst_mem_slave: bursts, strobes, FIXED, range errors,
// protocol errors, read stalls and mid-burst reset.
module tb_axi4_burst_mem_slave;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [3:0]  awid, arid, bid, rid;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;

   int          nvec = 0;
   int          nmis = 0;
   logic [31:0] wbuf [16];
   logic [31:0] rd_q [16];
   logic [1:0]  rr_q [16];
   logic        rl_q [16];
   logic [1:0]  resp;
   logic [31:0] exp_d [4];
   logic [1:0]  exp_r [4];

   always #5 aclk = ~aclk;

   axi4_burst_mem_slave dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
      .s_axi_awsize(awsize), .s_axi_awburst(awburst),
      .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
      .s_axi_arsize(arsize), .s_axi_arburst(arburst),
      .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
      .s_axi_rvalid(rvalid), .s_axi_rready(rready)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [3:0] strb, input int last_beat,
                            output logic [1:0] r);
      int t;
      awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
      t = 0;
      while (!awready && t < 50) begin @(posedge aclk); #1; t++; end
      check("aw_wait", t < 50, 1);
      @(posedge aclk); #1;
      awvalid = 1'b0;
      check("aw_wready_up", wready, 1);
      check("aw_awready_low", awready, 0);
      for (int i = 0; i <= int'(len); i++) begin
         wvalid = 1'b1; wdata = wbuf[i]; wstrb = strb; wlast = (i == last_beat);
         t = 0;
         while (!wready && t < 50) begin @(posedge aclk); #1; t++; end
         @(posedge aclk); #1;
      end
      wvalid = 1'b0; wlast = 1'b0;
      check("w_bvalid_up", bvalid, 1);
      check("w_wready_low", wready, 0);
      check("b_id", bid, id);
      r = bresp;
      bready = 1'b1;
      @(posedge aclk); #1;
      bready = 1'b0;
      check("b_awready_up", awready, 1);
   endtask

   task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
      int t;
      arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
      t = 0;
      while (!arready && t < 50) begin @(posedge aclk); #1; t++; end
      check("ar_wait", t < 50, 1);
      @(posedge aclk); #1;
      arvalid = 1'b0;
      check("ar_arready_low", arready, 0);
      rready = 1'b1;
      for (int i = 0; i <= int'(len); i++) begin
         check("r_rvalid_beat", rvalid, 1);
         check("r_rid", rid, id);
         rd_q[i] = rdata; rr_q[i] = rresp; rl_q[i] = rlast;
         @(posedge aclk); #1;
      end
      rready = 1'b0;
      check("r_rvalid_end", rvalid, 0);
      check("r_arready_end", arready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
      rready = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      check("rst_awready", awready, 0);
      check("rst_arready", arready, 0);
      check("rst_wready", wready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rlast", rlast, 0);
      check("rst_bresp", bresp, 0);
      check("rst_rresp", rresp, 0);
      check("rst_bid", bid, 0);
      check("rst_rid", rid, 0);
      check("rst_rdata", rdata, 0);
      aresetn = 1'b1;
      #1;
      check("rel_awready_pre", awready, 0);
      @(posedge aclk); #1;
      check("rel_awready", awready, 1);
      check("rel_arready", arready, 1);

      // 4-beat INCR write and readback
      wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
      axi_write(4'd3, 32'h10, 8'd3, 2'b01, 4'hF, 3, resp);
      check("incr_bresp", resp, 2'b00);
      axi_read(4'd5, 32'h10, 8'd3, 2'b01);
      exp_d = '{32'h11, 32'h22, 32'h33, 32'h44};
      for (int i = 0; i < 4; i++) begin
         check("incr_rdata", rd_q[i], exp_d[i]);
         check("incr_rresp", rr_q[i], 2'b00);
         check("incr_rlast", rl_q[i], (i == 3));
      end

      // partial strobes over a zeroed word
      wbuf[0] = 32'h0;
      axi_write(4'd1, 32'h40, 8'd0, 2'b01, 4'hF, 0, resp);
      wbuf[0] = 32'hAABBCCDD;
      axi_write(4'd1, 32'h40, 8'd0, 2'b01, 4'h5, 0, resp);
      check("strb_bresp", resp, 2'b00);
      axi_read(4'd2, 32'h40, 8'd0, 2'b01);
      check("strb_rdata", rd_q[0], 32'h00BB00DD);
      check("strb_rlast", rl_q[0], 1);

      // FIXED burst hits one word only
      wbuf[0] = 32'h12345678;
      axi_write(4'd4, 32'h24, 8'd0, 2'b01, 4'hF, 0, resp);
      wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3;
      axi_write(4'd4, 32'h20, 8'd2, 2'b00, 4'hF, 2, resp);
      check("fixed_bresp", resp, 2'b00);
      axi_read(4'd6, 32'h20, 8'd1, 2'b01);
      check("fixed_rdata20", rd_q[0], 32'd3);
      check("fixed_rdata24", rd_q[1], 32'h12345678);

      // burst running off the top of memory (word 1022 onward)
      wbuf[0] = 32'hA1; wbuf[1] = 32'hB2; wbuf[2] = 32'hC3; wbuf[3] = 32'hD4;
      axi_write(4'd7, 32'hFF8, 8'd3, 2'b01, 4'hF, 3, resp);
      check("oob_bresp", resp, 2'b10);
      axi_read(4'd8, 32'hFF8, 8'd3, 2'b01);
      exp_d = '{32'hA1, 32'hB2, 32'h0, 32'h0};
      exp_r = '{2'b00, 2'b00, 2'b10, 2'b10};
      for (int i = 0; i < 4; i++) begin
         check("oob_rdata", rd_q[i], exp_d[i]);
         check("oob_rresp", rr_q[i], exp_r[i]);
      end

      // WRAP burst, early wlast, missing wlast
      wbuf[0] = 32'hCAFEF00D;
      axi_write(4'd1, 32'h80, 8'd0, 2'b01, 4'hF, 0, resp);
      wbuf[0] = 32'hDEAD0001; wbuf[1] = 32'hDEAD0002; wbuf[2] = 32'hDEAD0003; wbuf[3] = 32'hDEAD0004;
      axi_write(4'd2, 32'h80, 8'd3, 2'b10, 4'hF, 3, resp);
      check("wrap_bresp", resp, 2'b10);
      axi_read(4'd3, 32'h80, 8'd0, 2'b01);
      check("wrap_mem_kept", rd_q[0], 32'hCAFEF00D);
      axi_read(4'd5, 32'h80, 8'd1, 2'b10);
      check("wrap_rd_rresp", rr_q[0], 2'b10);
      check("wrap_rd_rdata", rd_q[1], 32'h0);
      axi_write(4'd4, 32'h90, 8'd3, 2'b01, 4'hF, 1, resp);
      check("early_wlast_bresp", resp, 2'b10);
      axi_write(4'd4, 32'hA0, 8'd1, 2'b01, 4'hF, 99, resp);
      check("missing_wlast_bresp", resp, 2'b10);

      // read stall with rready 1,0,1,0 then reset on beat 2
      arid = 4'd9; araddr = 32'h10; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
      @(posedge aclk); #1;
      arvalid = 1'b0;
      rready = 1'b1;
      check("stall_b0_rdata", rdata, 32'h11);
      @(posedge aclk); #1;
      rready = 1'b0;
      check("stall_b1_rdata", rdata, 32'h22);
      @(posedge aclk); #1;
      check("stall_hold_rvalid", rvalid, 1);
      check("stall_hold_rdata", rdata, 32'h22);
      check("stall_hold_rid", rid, 4'd9);
      check("stall_hold_rlast", rlast, 0);
      rready = 1'b1;
      @(posedge aclk); #1;
      rready = 1'b0;
      check("stall_b2_rdata", rdata, 32'h33);
      @(posedge aclk); #1;
      check("stall_b2_hold", rdata, 32'h33);
      aresetn = 1'b0;
      #1;
      check("mid_rst_rvalid", rvalid, 0);
      check("mid_rst_rdata", rdata, 0);
      check("mid_rst_arready", arready, 0);
      check("mid_rst_rid", rid, 0);
      @(posedge aclk); #1;
      aresetn = 1'b1;
      #1;
      check("mid_rel_arready_pre", arready, 0);
      @(posedge aclk); #1;
      check("mid_rel_arready", arready, 1);
      check("mid_rel_awready", awready, 1);
      axi_read(4'd1, 32'h10, 8'd0, 2'b01);
      check("post_rst_rdata", rd_q[0], 32'h11);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/axi4_burst_mem_slave.md
# axi4_burst_mem_slave

Synthesizable AXI4 memory slave that sits directly downstream of the passthrough VIP inside `chip` and replaces the slave-side VIP memory model with real RTL. It accepts INCR and FIXED bursts from the master VIP through the passthrough. It stores data in an internal word array and returns OKAY/SLVERR responses. Write and read paths are independent, with one outstanding transaction each.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data bus width (32 or 64)
- ID_WIDTH, 4, AXI ID width
- MEM_DEPTH, 1024, memory size in DATA_WIDTH words
- BASE_ADDR, 0, byte address mapped to word 0
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address
- s_axi_awvalid in 1, s_axi_awready out 1  write address handshake
- s_axi_wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data
- s_axi_wvalid in 1, s_axi_wready out 1  write data handshake
- s_axi_bid/bresp  out  ID_WIDTH/2  write response
- s_axi_bvalid out 1, s_axi_bready in 1  write response handshake
- s_axi_arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read address
- s_axi_arvalid in 1, s_axi_arready out 1  read address handshake
- s_axi_rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data
- s_axi_rvalid out 1, s_axi_rready in 1  read data handshake

## Operation
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On AW handshake, latch id, addr, len, size, burst; clear beat count and error flag.
  - W_DATA: wready=1. Each W handshake writes the byte lanes enabled by wstrb, then advances the address and the count.
  - W_RESP: bvalid=1 with bid set to the latched id. On bready, return to W_IDLE.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On AR handshake, latch the fields and register mem[addr] into rdata.
  - R_DATA: rvalid=1. On R handshake, rdata is reloaded with the next beat in the same edge, giving one beat per cycle under continuous rready. rlast=1 when count==arlen. After the last handshake, return to R_IDLE.
- Address advance:
  - INCR: addr += 2^size. Addresses are treated as aligned; the low bits are taken from the word index.
  - FIXED: addr is unchanged.
- Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8).
- Error handling (SLVERR=2'b10, OKAY=2'b00):
  - Any beat with word index >= MEM_DEPTH, or addr < BASE_ADDR, is an error. That write beat is discarded and rdata returns 0.
  - WRAP burst (2'b10), reserved burst (2'b11), or size > log2(DATA_WIDTH/8) makes the whole burst an error. All beats are still accepted or returned; memory is not written and rdata is 0.
  - For writes, wlast not matching the final beat (early or missing) is an error. Beat count follows awlen regardless of wlast.
  - bresp = SLVERR if any beat of the burst erred. rresp is reported per beat.
- Same-edge read and write to one word: the read returns the old data.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0. Memory contents are not reset.
- awready and arready rise on the first aclk edge after aresetn deasserts.
- AW handshake at edge N: awready=0 and wready=1 from N+1.
- Final W beat at edge M: wready=0 and bvalid=1 from M+1.
- B handshake at edge K: awready=1 from K+1.
- AR handshake at edge N: rvalid=1 with beat 0 from N+1.
- R handshake on last beat at edge L: rvalid=0 and arready=1 from L+1.
- A burst of len+1 beats with rready held high takes len+1 consecutive rvalid cycles.
- AXI rule: valid never depends on ready. Once asserted, bvalid/rvalid and their payloads stay stable until the handshake.
- awlen=255 (256 beats): the counter is 8 bits and the terminal compare uses count==len, so no wrap occurs.
- Asserting aresetn low mid-burst immediately forces both FSMs to IDLE and applies the reset values above. A partial write burst leaves already-written words modified.

## Test plan
- INCR write of 4 beats to 0x10 (data 0x11..0x44, wstrb 0xF), then INCR read of 4 beats from 0x10 -> bresp=OKAY, rdata 0x11,0x22,0x33,0x44, rlast on beat 3 only, rid equals arid.
- Write 0xAABBCCDD with wstrb 0x5 over a word holding 0, then read it -> rdata 0x00BB00DD.
- FIXED write of 3 beats to 0x20 (data 1,2,3) -> reading 0x20 returns 3; 0x24 is unchanged.
- INCR read of 4 beats starting at word MEM_DEPTH-2 -> rresp OKAY,OKAY,SLVERR,SLVERR; beats 2-3 have rdata=0.
- WRAP write, and separately a write with wlast asserted on beat 1 of an awlen=3 burst -> bresp=SLVERR in both cases; the WRAP burst leaves memory unchanged.
- Read burst with rready toggling 1,0,1,0 -> rdata/rid/rlast stay stable while stalled. Then assert aresetn low on beat 2 -> rvalid=0 immediately, and arready=1 one edge after reset release.
